// File: rtl/posit_pio_bridge.sv
// Handshake bridge between level-only HPS PIO registers and the posit/float
// arithmetic core. Each go toggle becomes one valid/ready request. The bridge
// tracks the core's variable latency, latches the result and status for the
// HPS, and forces a NaR result if the core stalls past TIMEOUT cycles.
//
// Ports:
//   clock, reset_n          fabric clock, async active-low reset
//   pio_num1/pio_num2       operands from HPS
//   pio_ctrl                [0] go toggle, [2:1] opcode
//   pio_result              last result (or NAR on timeout)
//   pio_status              [0] busy [1] done [2] timeout [3] overrun [15:8] seq
//   core_num1/num2/op       captured request payload
//   core_in_valid/ready     request handshake
//   core_result/out_valid   single-cycle response from the core
module posit_pio_bridge #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      TIMEOUT = 1024,
  parameter logic [WIDTH-1:0] NAR     = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pio_num1,
  input  logic [WIDTH-1:0] pio_num2,
  input  logic [31:0]      pio_ctrl,
  output logic [WIDTH-1:0] pio_result,
  output logic [31:0]      pio_status,
  output logic [WIDTH-1:0] core_num1,
  output logic [WIDTH-1:0] core_num2,
  output logic [1:0]       core_op,
  output logic             core_in_valid,
  input  logic             core_in_ready,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_out_valid
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       seq_q, seq_d;
  logic             go_prev_q, go_prev_d;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             ovr_q, ovr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic [1:0]       op_q, op_d;

  logic             start;
  logic             expired;

  // A toggle only counts once the current level has been sampled after reset.
  assign start   = armed_q && (pio_ctrl[0] != go_prev_q);
  assign expired = (timer_q == TW'(TIMEOUT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    seq_d     = seq_q;
    go_prev_d = pio_ctrl[0];
    armed_d   = 1'b1;
    busy_d    = busy_q;
    done_d    = done_q;
    tmo_d     = tmo_q;
    ovr_d     = ovr_q;
    valid_d   = valid_q;
    result_d  = result_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    op_d      = op_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num1_d  = pio_num1;
          num2_d  = pio_num2;
          op_d    = pio_ctrl[2:1];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          ovr_d   = 1'b0;
          timer_d = '0;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = timer_q + TW'(1);
        if (start) ovr_d = 1'b1;
        // Responses cannot arrive before the request is accepted, so expiry here is final.
        if (expired) begin
          result_d = NAR;
          tmo_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          valid_d  = 1'b0;
          state_d  = ST_IDLE;
        end else if (core_in_ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (start) ovr_d = 1'b1;
        // A response on the expiry cycle still wins over the timeout.
        if (core_out_valid) begin
          result_d = core_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          seq_d    = seq_q + 8'd1;
          state_d  = ST_IDLE;
        end else if (expired) begin
          result_d = NAR;
          tmo_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      seq_q     <= '0;
      go_prev_q <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      seq_q     <= seq_d;
      go_prev_q <= go_prev_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      op_q      <= op_d;
    end
  end

  assign pio_result    = result_q;
  assign pio_status    = {16'd0, seq_q, 4'd0, ovr_q, tmo_q, done_q, busy_q};
  assign core_num1     = num1_q;
  assign core_num2     = num2_q;
  assign core_op       = op_q;
  assign core_in_valid = valid_q;

endmodule

// File: doc/posit_pio_bridge.md
# posit_pio_bridge

Control/handshake stage between the HPS PIO exports (num1, num2, control, result, status) and the posit/float arithmetic core in the Arria 10 FPGA fabric. It converts level-only PIO registers into one valid/ready transaction per software request, tracks the core's variable latency, and latches the result and status for the HPS to read back. A watchdog guarantees forward progress if the core stalls.

## Interface
- WIDTH, 32: operand/result width.
- TIMEOUT, 1024: cycles allowed from issue to core response; power of two, ≥4.
- NAR, {1'b1,{WIDTH-1{1'b0}}}: result value on timeout (posit NaR).

- clock  in  1  fabric clock (fpga_clk_100 domain, same as PIO slaves).
- reset_n  in  1  reset, asynchronous, active-low.
- pio_num1  in  WIDTH  operand A from HPS.
- pio_num2  in  WIDTH  operand B from HPS.
- pio_ctrl  in  32  [0] go toggle, [2:1] opcode, rest ignored.
- pio_result  out  WIDTH  last result.
- pio_status  out  32  [0] busy, [1] done, [2] timeout, [3] overrun, [15:8] seq count, rest 0.
- core_num1  out  WIDTH  captured operand A.
- core_num2  out  WIDTH  captured operand B.
- core_op  out  2  captured opcode.
- core_in_valid  out  1  request valid.
- core_in_ready  in  1  core accepts request.
- core_result  in  WIDTH  core result.
- core_out_valid  in  1  core result valid (single-cycle pulse).

## Operation
- Reset: all outputs 0; state IDLE; timer 0; seq 0; go_prev 0; armed 0.
- armed: first clock after reset release loads go_prev ← pio_ctrl[0] and sets armed, no request. Stale toggle level never starts an op.
- Start event: armed && (pio_ctrl[0] ≠ go_prev). go_prev ← pio_ctrl[0] every cycle once armed.
- FSM IDLE: on start → capture pio_num1/num2/ctrl[2:1] into core_num1/num2/op; busy←1, done←0, timeout←0, timer←0; → ISSUE.
- ISSUE: core_in_valid=1; operands held stable. On core_in_ready → WAIT. Timer increments.
- WAIT: core_in_valid=0. On core_out_valid → pio_result←core_result, done←1, busy←0, seq←seq+1 (mod 256); → IDLE.
- Timeout: in ISSUE or WAIT, timer == TIMEOUT-1 and no core_out_valid that cycle → pio_result←NAR, timeout←1, done←1, busy←0, seq unchanged; → IDLE. core_in_valid drops same edge (request abandoned).
- Simultaneous core_out_valid and timer expiry: result wins, no timeout.
- Start event while busy: dropped; overrun←1 (sticky until next accepted start).
- core_out_valid in IDLE or ISSUE: ignored.
- Late core response after timeout: ignored (state IDLE).
- core_num*/core_op hold last captured values in IDLE.
- Asynchronous reset mid-operation: immediate return to reset values; in-flight request abandoned.

## Timing
- Cycle 0: pio_ctrl[0] toggles. Edge ending cycle 0: capture, state ISSUE.
- Cycle 1: core_in_valid=1, busy=1. If core_in_ready, edge ending cycle 1 → WAIT.
- Core result pulse in cycle N ≥ 2 → pio_result/done visible cycle N+1.
- Minimum toggle-to-done: 3 cycles with a zero-wait 1-cycle core.
- Timer counts from cycle 1; timeout visible in cycle TIMEOUT+1 if no response.
- Back-to-back: new start accepted the cycle after done asserts (state IDLE).
- All outputs registered; no combinational path from core inputs to pio outputs.

## Test plan
- Reset with pio_ctrl=0x1, release, hold 20 cycles → no core_in_valid, status 0x0.
- Toggle go with num1=0x40000000, num2=0x40000000, op=0, core ready immediately, returns 0x48000000 one cycle later → pio_result=0x48000000 at cycle 3, status=0x0000_0102.
- Core holds core_in_ready=0 for 5 cycles → core_in_valid held high 6 cycles, operands stable, then normal completion.
- Core never responds (TIMEOUT=16) → at cycle 17 pio_result=0x80000000, status bits timeout=1, done=1, busy=0, seq unchanged; later core_out_valid ignored.
- Second toggle during busy → overrun=1, single core request issued; next toggle after done clears overrun, seq increments 1→2.
- Assert reset_n=0 during WAIT → outputs 0 same cycle asynchronously; after release, no request until a fresh toggle.
